// File: rtl/inst_cache_responder.sv
// -----------------------------------------------------------------------------
// inst_cache_responder
//
// Slave end of the instruction bus. A direct-mapped, read-only instruction
// cache that answers hits in the same cycle and stalls fetch on a miss while
// one line is refilled from backing memory, one word per req/ack beat.
//
// Ports:
//   i_clock    - clock
//   i_reset    - synchronous, active-high reset
//   i_addr     - fetch byte address from the IF stage
//   o_inst     - instruction word (NOP whenever o_busy is high)
//   o_busy     - miss/refill in progress; IF holds i_addr and ignores o_inst
//   i_flush    - invalidate every line (fence.i)
//   o_memAddr  - backing-memory word address (byte address, word aligned)
//   o_memRead  - backing-memory read request, held until acknowledged
//   i_memAck   - backing-memory acknowledge; i_memData valid this cycle
//   i_memData  - backing-memory read data
// -----------------------------------------------------------------------------
module inst_cache_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic                  o_busy,
  input  logic                  i_flush,
  output logic [ADDR_WIDTH-1:0] o_memAddr,
  output logic                  o_memRead,
  input  logic                  i_memAck,
  input  logic [DATA_WIDTH-1:0] i_memData
);

  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W - BYTE_W;
  localparam int SEL_W  = IDX_W + OFF_W;

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [0:0] {
    S_IDLE,
    S_FILL
  } state_t;

  // Control state
  state_t               r_state;
  logic [OFF_W-1:0]     r_cnt;
  logic                 r_flushPend;
  logic [LINES-1:0]     r_valid;

  // Latched line being refilled
  logic [TAG_W-1:0]     r_fillTag;
  logic [IDX_W-1:0]     r_fillIdx;

  // Storage arrays: asynchronous read, written on the clock edge, never reset
  logic [TAG_W-1:0]      r_tagArr  [LINES];
  logic [DATA_WIDTH-1:0] r_dataArr [LINES*WORDS_PER_LINE];

  // Address decode
  logic [TAG_W-1:0]      w_tag;
  logic [IDX_W-1:0]      w_idx;
  logic [OFF_W-1:0]      w_off;
  logic [SEL_W-1:0]      w_rdSel;
  logic [SEL_W-1:0]      w_wrSel;
  logic                  w_hit;
  logic                  w_lastBeat;
  logic                  w_wrEn;
  logic                  w_startFill;
  logic [ADDR_WIDTH-1:0] w_fillAddr;
  logic                  w_unused_byteLane;

  assign w_tag   = i_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_idx   = i_addr[BYTE_W+OFF_W +: IDX_W];
  assign w_off   = i_addr[BYTE_W +: OFF_W];
  assign w_rdSel = {w_idx, w_off};
  assign w_wrSel = {r_fillIdx, r_cnt};

  // Byte-lane bits of the fetch address carry no information for a word cache.
  assign w_unused_byteLane = ^i_addr[BYTE_W-1:0];

  // A hit is only reported from IDLE: during a refill the arrays are mid-update
  // and the bus is stalled anyway.
  assign w_hit = r_valid[w_idx] && (r_tagArr[w_idx] == w_tag) && (r_state == S_IDLE);

  assign w_lastBeat  = (r_cnt == OFF_W'(WORDS_PER_LINE - 1));
  assign w_wrEn      = !i_reset && (r_state == S_FILL) && i_memAck;
  assign w_startFill = !i_reset && (r_state == S_IDLE) && !w_hit;
  assign w_fillAddr  = {r_fillTag, r_fillIdx, r_cnt, {BYTE_W{1'b0}}};

  // Bus-facing outputs. Reset forces the idle/quiet values in the same cycle so
  // an abandoned refill drops its request immediately.
  always_comb begin
    o_inst    = NOP;
    o_busy    = 1'b0;
    o_memRead = 1'b0;
    o_memAddr = '0;
    if (!i_reset) begin
      if (r_state == S_FILL) begin
        o_busy    = 1'b1;
        o_memRead = 1'b1;
        o_memAddr = w_fillAddr;
      end else if (w_hit) begin
        o_inst = r_dataArr[w_rdSel];
      end else begin
        o_busy = 1'b1;
      end
    end
  end

  // Refill controller. A flush clears every valid bit at once; if it lands
  // during a refill the fill still runs to completion (the memory transaction
  // is never aborted) but the refilled line is left invalid.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_flushPend <= 1'b0;
      r_valid     <= '0;
    end else begin
      if (i_flush) begin
        r_valid <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (!w_hit) begin
            r_cnt   <= '0;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (i_flush) begin
            r_flushPend <= 1'b1;
          end
          if (i_memAck) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_lastBeat) begin
              r_state     <= S_IDLE;
              r_flushPend <= 1'b0;
              // A flush on the final beat also suppresses the valid bit.
              if (!r_flushPend && !i_flush) begin
                r_valid[r_fillIdx] <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line base captured on the miss cycle; i_addr is ignored until the fill ends.
  always_ff @(posedge i_clock) begin
    if (w_startFill) begin
      r_fillTag <= w_tag;
      r_fillIdx <= w_idx;
    end
  end

  // Array writes: one data word per acknowledged beat, tag with the last beat.
  always_ff @(posedge i_clock) begin
    if (w_wrEn) begin
      r_dataArr[w_wrSel] <= i_memData;
      if (w_lastBeat) begin
        r_tagArr[r_fillIdx] <= r_fillTag;
      end
    end
  end

endmodule

// File: tb/tb_inst_cache_responder.sv
module tb_inst_cache_responder;

  localparam int          WPL = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_addr;
  logic [31:0] o_inst;
  logic        o_busy;
  logic        i_flush;
  logic [31:0] o_memAddr;
  logic        o_memRead;
  logic        i_memAck;
  logic [31:0] i_memData;

  int n_vec = 0;
  int n_err = 0;

  inst_cache_responder #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .LINES         (16),
    .WORDS_PER_LINE(WPL)
  ) dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_addr   (i_addr),
    .o_inst   (o_inst),
    .o_busy   (o_busy),
    .i_flush  (i_flush),
    .o_memAddr(o_memAddr),
    .o_memRead(o_memRead),
    .i_memAck (i_memAck),
    .i_memData(i_memData)
  );

  always #5 i_clock = ~i_clock;

  // Backing-memory contents: a recognisable word per address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Presents address a and plays the memory side until the access resolves.
  // waits      : memory wait cycles before each ack
  // exp_miss   : access is expected to miss and refill
  // flush_beat : beat number during which i_flush is pulsed (-1 = none)
  // exp_busy   : o_busy expected right after the refill (flushed line)
  task automatic do_access(input logic [31:0] a, input int waits, input bit exp_miss,
                           input int flush_beat, input bit exp_busy);
    logic [31:0] base;
    int beats, wt, busy, guard;
    base  = a & 32'hFFFF_FFF0;
    beats = 0; wt = 0; busy = 0; guard = 0;
    i_addr   = a;
    i_memAck = 1'b0;
    i_flush  = 1'b0;
    #1;
    while (o_busy && beats < WPL && guard < 200) begin
      busy++;
      guard++;
      chk("inst_nop_while_busy", o_inst, NOP);
      if (o_memRead) begin
        chk("memaddr", o_memAddr, base + 32'(beats * 4));
        i_flush = (beats == flush_beat) && (wt == 0);
        if (wt < waits) begin
          i_memAck = 1'b0;
          wt++;
        end else begin
          i_memAck  = 1'b1;
          i_memData = memf(o_memAddr);
          beats++;
          wt = 0;
        end
      end else begin
        i_memAck = 1'b0;
      end
      tick();
      i_memAck = 1'b0;
      i_flush  = 1'b0;
      #1;
    end
    chk("busy_cycles", busy, exp_miss ? 1 + WPL * (1 + waits) : 0);
    chk("beats", beats, exp_miss ? WPL : 0);
    chk("busy_after", o_busy, exp_busy);
    if (!exp_busy) begin
      chk("inst", o_inst, memf(a & 32'hFFFF_FFFC));
      chk("memread_idle", o_memRead, 1'b0);
      tick();
    end
  endtask

  initial begin
    i_reset   = 1'b1;
    i_addr    = 32'h100;
    i_flush   = 1'b0;
    i_memAck  = 1'b0;
    i_memData = 32'h0;

    // Reset state
    tick();
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_memread", o_memRead, 1'b0);
    chk("rst_inst", o_inst, NOP);
    chk("rst_memaddr", o_memAddr, 32'h0);
    tick();
    i_reset = 1'b0;

    // Cold miss, then zero-latency hits on the rest of the line
    do_access(32'h100, 0, 1'b1, -1, 1'b0);
    do_access(32'h104, 0, 1'b0, -1, 1'b0);
    do_access(32'h108, 0, 1'b0, -1, 1'b0);
    do_access(32'h10C, 0, 1'b0, -1, 1'b0);

    // Stray ack with no request outstanding is ignored
    i_addr    = 32'h104;
    i_memAck  = 1'b1;
    i_memData = 32'hDEAD_BEEF;
    #1;
    chk("stray_ack_busy", o_busy, 1'b0);
    tick();
    i_memAck = 1'b0;
    do_access(32'h104, 0, 1'b0, -1, 1'b0);

    // Conflict on index 0
    do_access(32'h200, 0, 1'b1, -1, 1'b0);
    do_access(32'h100, 0, 1'b1, -1, 1'b0);

    // Two wait cycles per beat: 1 + 4*3 = 13 busy cycles
    do_access(32'h500, 2, 1'b1, -1, 1'b0);
    do_access(32'h508, 0, 1'b0, -1, 1'b0);

    // Flush during the second beat: line left invalid, 0x100 flushed too
    do_access(32'h100, 0, 1'b1, -1, 1'b0);
    do_access(32'h300, 0, 1'b1, 1, 1'b1);
    do_access(32'h300, 0, 1'b1, -1, 1'b0);
    do_access(32'h100, 0, 1'b1, -1, 1'b0);

    // Reset mid-fill
    i_addr = 32'h400;
    #1;
    chk("rf_miss_busy", o_busy, 1'b1);
    tick();
    chk("rf_memread", o_memRead, 1'b1);
    chk("rf_addr0", o_memAddr, 32'h400);
    i_memAck  = 1'b1;
    i_memData = memf(32'h400);
    tick();
    i_memAck = 1'b0;
    #1;
    chk("rf_addr1", o_memAddr, 32'h404);
    i_reset = 1'b1;
    #1;
    chk("rf_rst_memread", o_memRead, 1'b0);
    chk("rf_rst_busy", o_busy, 1'b0);
    chk("rf_rst_inst", o_inst, NOP);
    chk("rf_rst_memaddr", o_memAddr, 32'h0);
    tick();
    i_reset = 1'b0;
    #1;
    chk("rf_after_memread", o_memRead, 1'b0);
    chk("rf_after_busy", o_busy, 1'b1);
    do_access(32'h400, 0, 1'b1, -1, 1'b0);
    do_access(32'h40C, 0, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
